regfile_scoreboard: RTL

//  Register file that sinks the write-back stream (wen/w_addr/w_data) and serves two

---
 rtl/regfile_scoreboard.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass, two registered read ports and per-register
// pending-write counters that stall decode on RAW hazards or counter saturation.
module regfile_scoreboard #(
   parameter int DSIZE = 16,
   parameter int ASIZE = 4,
   parameter int CNTW  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [ASIZE-1:0] w_addr,
   input  logic [DSIZE-1:0] w_data,
   input  logic             ren,
   input  logic             rv0,
   input  logic             rv1,
   input  logic [ASIZE-1:0] raddr0,
   input  logic [ASIZE-1:0] raddr1,
   input  logic             issue_en,
   input  logic [ASIZE-1:0] issue_addr,
   output logic [DSIZE-1:0] rdata0,
   output logic [DSIZE-1:0] rdata1,
   output logic             stall,
   output logic             err_uflow
);

   localparam int NREG = 1 << ASIZE;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [DSIZE-1:0]           mem_reg [NREG];
   logic [NREG-1:0][CNTW-1:0]  cnt_reg;
   logic [NREG-1:0][CNTW-1:0]  cnt_next;
   logic [NREG-1:0]            inc_vec;
   logic [NREG-1:0]            dec_vec;
   logic [NREG-1:0]            uflow_vec;

   logic [CNTW-1:0]  cnt_rd0;
   logic [CNTW-1:0]  cnt_rd1;
   logic [CNTW-1:0]  cnt_iss;
   logic             wb_hit0;
   logic             wb_hit1;
   logic             wb_hit_iss;
   logic             haz0;
   logic             haz1;
   logic             full;
   logic             read_go;
   logic             issue_go;
   logic [DSIZE-1:0] rdata0_next;
   logic [DSIZE-1:0] rdata1_next;

   assign cnt_rd0    = cnt_reg[raddr0];
   assign cnt_rd1    = cnt_reg[raddr1];
   assign cnt_iss    = cnt_reg[issue_addr];
   assign wb_hit0    = wen && (w_addr == raddr0);
   assign wb_hit1    = wen && (w_addr == raddr1);
   assign wb_hit_iss = wen && (w_addr == issue_addr);

   // A single outstanding producer retiring this cycle is covered by the bypass path.
   assign haz0 = rv0 && (raddr0 != '0) && (cnt_rd0 != '0)
                 && !(wb_hit0 && (cnt_rd0 == CNTW'(1)));
   assign haz1 = rv1 && (raddr1 != '0) && (cnt_rd1 != '0)
                 && !(wb_hit1 && (cnt_rd1 == CNTW'(1)));
   assign full = issue_en && (issue_addr != '0) && (cnt_iss == CNT_MAX) && !wb_hit_iss;

   assign stall    = haz0 | haz1 | full;
   assign read_go  = ren && !stall;
   assign issue_go = issue_en && !stall;

   always_comb begin
      rdata0_next = mem_reg[raddr0];
      rdata1_next = mem_reg[raddr1];
      if (raddr0 == '0) begin
         rdata0_next = '0;
      end else if (wb_hit0) begin
         rdata0_next = w_data;
      end
      if (raddr1 == '0) begin
         rdata1_next = '0;
      end else if (wb_hit1) begin
         rdata1_next = w_data;
      end
   end

   // Register 0 keeps a constant zero counter; a write-back to it neither retires nor errors.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
         if (gi == 0) begin : g_zero
            assign inc_vec[gi]   = 1'b0;
            assign dec_vec[gi]   = 1'b0;
            assign uflow_vec[gi] = 1'b0;
            assign cnt_next[gi]  = '0;
         end else begin : g_reg
            assign inc_vec[gi]   = issue_go && (issue_addr == ASIZE'(gi));
            assign dec_vec[gi]   = wen && (w_addr == ASIZE'(gi));
            assign uflow_vec[gi] = dec_vec[gi] && !inc_vec[gi] && (cnt_reg[gi] == '0);
            assign cnt_next[gi]  =
               (inc_vec[gi] && !dec_vec[gi])                          ? cnt_reg[gi] + CNTW'(1) :
               (dec_vec[gi] && !inc_vec[gi] && (cnt_reg[gi] != '0))   ? cnt_reg[gi] - CNTW'(1) :
                                                                        cnt_reg[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg   <= '0;
         err_uflow <= 1'b0;
      end else begin
         cnt_reg   <= cnt_next;
         err_uflow <= err_uflow | (|uflow_vec);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wen && (w_addr != '0)) begin
         mem_reg[w_addr] <= w_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (read_go) begin
         rdata0 <= rdata0_next;
         rdata1 <= rdata1_next;
      end
   end

endmodule
